// File: rtl/y86_regfile.sv
// y86_regfile: Y86-64 architectural register file with commit-status latch and retire counter.
// Ports: clk_i/rst_i (sync, active-high); writeback wb_valid_i, stat_i, dstE_i/valE_i, dstM_i/valM_i;
// read ports srcA_i->valA_o, srcB_i->valB_o; status stat_o, halted_o; retired count instret_o.
// Define REGFILE_BYPASS_EN for same-cycle write-through on both read ports.
module y86_regfile #(
  parameter int NREGS = 15,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [2:0]  stat_i,
  input  logic [3:0]  dstE_i,
  input  logic [63:0] valE_i,
  input  logic [3:0]  dstM_i,
  input  logic [63:0] valM_i,
  input  logic [3:0]  srcA_i,
  input  logic [3:0]  srcB_i,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o,
  output logic [2:0]  stat_o,
  output logic        halted_o,
  output logic [63:0] instret_o
);
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] INS = 3'd4;
  logic [63:0] regs [NREGS];
  logic run, commit;
  assign run = stat_o == AOK;
  assign halted_o = ~run;
  // reset wins over a simultaneous commit, so the reset cycle never commits
  assign commit = wb_valid_i & run & (stat_i == AOK) & ~rst_i;
  function automatic logic ok(input logic [3:0] id);
    return id != RNONE && 32'(id) < NREGS;
  endfunction
  function automatic logic [63:0] rd(input logic [3:0] id);
    return ok(id) ? regs[id] : '0;
  endfunction
`ifdef REGFILE_BYPASS_EN
  function automatic logic [63:0] port(input logic [3:0] id);
    return commit && ok(dstM_i) && id == dstM_i ? valM_i :
           commit && ok(dstE_i) && id == dstE_i ? valE_i : rd(id);
  endfunction
`else
  function automatic logic [63:0] port(input logic [3:0] id);
    return rd(id);
  endfunction
`endif
  always_comb begin
    valA_o = port(srcA_i);
    valB_o = port(srcB_i);
  end
  always_ff @(posedge clk_i)
    for (int r = 0; r < NREGS; r++)
      if (rst_i) regs[r] <= '0;
      else if (commit && ok(dstM_i) && dstM_i == 4'(r)) regs[r] <= valM_i;
      else if (commit && ok(dstE_i) && dstE_i == 4'(r)) regs[r] <= valE_i;
  // out-of-range status codes stop the machine as INS
  always_ff @(posedge clk_i)
    if (rst_i) begin
      stat_o <= AOK;
      instret_o <= '0;
    end else if (commit) instret_o <= instret_o + 64'd1;
    else if (wb_valid_i && run) stat_o <= (stat_i inside {3'd2, 3'd3, 3'd4}) ? stat_i : INS;
endmodule

// File: tb/tb_y86_regfile.sv
// tb_y86_regfile: randomized self-checking bench for y86_regfile against a behavioural model.
module tb_y86_regfile;
  logic clk_i = 1'b0;
  logic rst_i, wb_valid_i;
  logic [2:0] stat_i;
  logic [3:0] dstE_i, dstM_i, srcA_i, srcB_i;
  logic [63:0] valE_i, valM_i;
  logic [63:0] valA_o, valB_o, instret_o;
  logic [2:0] stat_o;
  logic halted_o;
  int checks = 0, errors = 0;
  logic [63:0] m [15];
  logic [2:0] mstat;
  logic [63:0] mret;

  y86_regfile dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .stat_i(stat_i),
    .dstE_i(dstE_i), .valE_i(valE_i), .dstM_i(dstM_i), .valM_i(valM_i),
    .srcA_i(srcA_i), .srcB_i(srcB_i), .valA_o(valA_o), .valB_o(valB_o),
    .stat_o(stat_o), .halted_o(halted_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] exp_rd(input logic [3:0] id);
    logic c;
    c = wb_valid_i && !rst_i && mstat == 3'd1 && stat_i == 3'd1;
`ifdef REGFILE_BYPASS_EN
    if (c && dstM_i != 4'hF && id == dstM_i) return valM_i;
    if (c && dstE_i != 4'hF && id == dstE_i) return valE_i;
`endif
    return id < 4'd15 ? m[id] : 64'h0;
  endfunction

  task automatic set_in(input logic v, input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm, input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk_i);
    wb_valid_i = v; stat_i = st; dstE_i = de; valE_i = ve; dstM_i = dm; valM_i = vm; srcA_i = sa; srcB_i = sb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      for (int i = 0; i < 15; i++) m[i] = 64'h0;
      mstat = 3'd1;
      mret = 64'h0;
    end else if (wb_valid_i && mstat == 3'd1) begin
      if (stat_i == 3'd1) begin
        if (dstE_i < 4'd15) m[dstE_i] = valE_i;
        if (dstM_i < 4'd15) m[dstM_i] = valM_i;
        mret = mret + 64'd1;
      end else mstat = (stat_i >= 3'd2 && stat_i <= 3'd4) ? stat_i : 3'd4;
    end
    #1;
  endtask

  task automatic do_reset(input logic v);
    set_in(v, 3'd1, 4'd4, 64'h55, 4'd6, 64'h66, 4'd4, 4'd6);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'(i), 4'(15 - i));
      checks += 2;
      if (valA_o !== 64'h0) begin errors++; $display("FAIL reset_rdA id=%0d got=%h exp=0", i, valA_o); end
      if (valB_o !== 64'h0) begin errors++; $display("FAIL reset_rdB id=%0d got=%h exp=0", 15 - i, valB_o); end
    end
    checks += 3;
    if (stat_o !== 3'd1) begin errors++; $display("FAIL reset_stat got=%0d exp=1", stat_o); end
    if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted_o); end
    if (instret_o !== 64'h0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
  endtask

  task automatic test_commit();
    set_in(1'b1, 3'd1, 4'd0, 64'h1234, 4'd3, 64'hDEAD, 4'hF, 4'hF);
    tick();
    set_in(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd0, 4'd3);
    checks += 3;
    if (valA_o !== 64'h1234) begin errors++; $display("FAIL commit_rA got=%h exp=1234", valA_o); end
    if (valB_o !== 64'hDEAD) begin errors++; $display("FAIL commit_rB got=%h exp=dead", valB_o); end
    if (instret_o !== 64'd1) begin errors++; $display("FAIL commit_instret got=%0d exp=1", instret_o); end
  endtask

  task automatic test_same_dst();
    set_in(1'b1, 3'd1, 4'd5, 64'd7, 4'd5, 64'd9, 4'hF, 4'hF);
    tick();
    set_in(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd5, 4'd5);
    checks++;
    if (valA_o !== 64'd9) begin errors++; $display("FAIL same_dst got=%0d exp=9", valA_o); end
  endtask

  task automatic test_bypass();
    logic [63:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 64'hAA;
`else
    exp = 64'h0;
`endif
    set_in(1'b1, 3'd1, 4'd2, 64'hAA, 4'hF, 64'h0, 4'd2, 4'd3);
    checks += 2;
    if (valA_o !== exp) begin errors++; $display("FAIL bypass_same got=%h exp=%h", valA_o, exp); end
    if (valB_o !== 64'hDEAD) begin errors++; $display("FAIL bypass_other got=%h exp=dead", valB_o); end
    tick();
    set_in(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'd2, 4'd2);
    checks++;
    if (valA_o !== 64'hAA) begin errors++; $display("FAIL bypass_next got=%h exp=aa", valA_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom), 3'd1, 4'($urandom), {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom},
             4'($urandom), 4'($urandom));
      checks += 2;
      if (valA_o !== exp_rd(srcA_i)) begin errors++; $display("FAIL rand_rA n=%0d id=%0d got=%h exp=%h", n, srcA_i, valA_o, exp_rd(srcA_i)); end
      if (valB_o !== exp_rd(srcB_i)) begin errors++; $display("FAIL rand_rB n=%0d id=%0d got=%h exp=%h", n, srcB_i, valB_o, exp_rd(srcB_i)); end
      tick();
      checks += 2;
      if (instret_o !== mret) begin errors++; $display("FAIL rand_instret n=%0d got=%0d exp=%0d", n, instret_o, mret); end
      if (stat_o !== mstat) begin errors++; $display("FAIL rand_stat n=%0d got=%0d exp=%0d", n, stat_o, mstat); end
    end
  endtask

  task automatic test_halt();
    logic [63:0] r1, ret;
    r1 = m[1];
    ret = mret;
    set_in(1'b0, 3'd2, 4'd1, 64'd5, 4'hF, 64'h0, 4'd1, 4'd1);
    tick();
    checks++;
    if (stat_o !== 3'd1) begin errors++; $display("FAIL halt_novalid got=%0d exp=1", stat_o); end
    set_in(1'b1, 3'd2, 4'd1, 64'd5, 4'hF, 64'h0, 4'd1, 4'd1);
    tick();
    checks += 4;
    if (valA_o !== r1) begin errors++; $display("FAIL halt_r1 got=%h exp=%h", valA_o, r1); end
    if (stat_o !== 3'd2) begin errors++; $display("FAIL halt_stat got=%0d exp=2", stat_o); end
    if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_halted got=%b exp=1", halted_o); end
    if (instret_o !== ret) begin errors++; $display("FAIL halt_instret got=%0d exp=%0d", instret_o, ret); end
    for (int n = 0; n < 20; n++) begin
      set_in(1'b1, (n == 10) ? 3'd3 : 3'd1, 4'($urandom), {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom},
             4'($urandom), 4'($urandom));
      checks += 2;
      if (valA_o !== exp_rd(srcA_i)) begin errors++; $display("FAIL stop_rA n=%0d got=%h exp=%h", n, valA_o, exp_rd(srcA_i)); end
      if (valB_o !== exp_rd(srcB_i)) begin errors++; $display("FAIL stop_rB n=%0d got=%h exp=%h", n, valB_o, exp_rd(srcB_i)); end
      tick();
      checks += 2;
      if (instret_o !== ret) begin errors++; $display("FAIL stop_instret n=%0d got=%0d exp=%0d", n, instret_o, ret); end
      if (stat_o !== 3'd2) begin errors++; $display("FAIL stop_stat n=%0d got=%0d exp=2", n, stat_o); end
    end
  endtask

  task automatic test_reset_in_stop();
    do_reset(1'b1);
    for (int i = 0; i < 15; i++) begin
      set_in(1'b0, 3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 4'(i), 4'(i));
      checks++;
      if (valA_o !== 64'h0) begin errors++; $display("FAIL rst_stop_reg id=%0d got=%h exp=0", i, valA_o); end
    end
    checks += 3;
    if (stat_o !== 3'd1) begin errors++; $display("FAIL rst_stop_stat got=%0d exp=1", stat_o); end
    if (halted_o !== 1'b0) begin errors++; $display("FAIL rst_stop_halted got=%b exp=0", halted_o); end
    if (instret_o !== 64'h0) begin errors++; $display("FAIL rst_stop_instret got=%0d exp=0", instret_o); end
  endtask

  task automatic test_bad_stat();
    logic [2:0] codes [4];
    codes = '{3'd0, 3'd5, 3'd7, 3'd4};
    for (int k = 0; k < 4; k++) begin
      do_reset(1'b0);
      set_in(1'b1, codes[k], 4'd7, 64'h77, 4'hF, 64'h0, 4'd7, 4'd7);
      tick();
      checks += 3;
      if (stat_o !== mstat) begin errors++; $display("FAIL bad_stat code=%0d got=%0d exp=%0d", codes[k], stat_o, mstat); end
      if (valA_o !== 64'h0) begin errors++; $display("FAIL bad_stat_reg code=%0d got=%h exp=0", codes[k], valA_o); end
      if (halted_o !== 1'b1) begin errors++; $display("FAIL bad_stat_halted code=%0d got=%b exp=1", codes[k], halted_o); end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    test_reset();
    test_commit();
    test_same_dst();
    test_bypass();
    test_random();
    test_halt();
    test_reset_in_stop();
    test_random();
    test_bad_stat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/y86_regfile.md
# y86_regfile

Architectural register file and commit-status tracker for the Y86-64 pipeline: the receiving end of the writeback stage. It accepts committed `valE`/`valM` results with their destination IDs, updates the 15 program registers, and serves two combinational read ports to decode. It also latches the first non-AOK program status, blocks all later commits, and counts retired instructions.

## Interface
Parameters:
- `NREGS`, 15: number of architectural registers, IDs 0..14.
- `RNONE`, 4'hF: register ID meaning "no register".

Ports (one clock; reset is synchronous and active-high):
- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `wb_valid_i` input 1: writeback stage presents a retiring instruction this cycle.
- `stat_i` input 3: status of the retiring instruction; AOK=1, HLT=2, ADR=3, INS=4.
- `dstE_i` input 4: destination ID for `valE_i`.
- `valE_i` input 64: ALU result.
- `dstM_i` input 4: destination ID for `valM_i`.
- `valM_i` input 64: memory result.
- `srcA_i` input 4: read port A ID.
- `srcB_i` input 4: read port B ID.
- `valA_o` output 64: register `srcA_i` contents.
- `valB_o` output 64: register `srcB_i` contents.
- `stat_o` output 3: latched program status.
- `halted_o` output 1: high when `stat_o` is not AOK.
- `instret_o` output 64: retired-instruction count.

## Operation
- State is two-valued:
  - RUN: `stat_o`=AOK.
  - STOP: `stat_o` holds HLT, ADR or INS.
- A commit is `wb_valid_i` & RUN & `stat_i`==AOK. Only a commit writes registers and increments `instret_o`.
- On a commit:
  - If `dstE_i`!=RNONE, write `valE_i` to `dstE_i`.
  - If `dstM_i`!=RNONE, write `valM_i` to `dstM_i`.
  - If both IDs are equal and not RNONE, `valM_i` wins.
- RUN→STOP: on `wb_valid_i` & RUN & `stat_i`!=AOK, latch `stat_i` into `stat_o`. That instruction writes nothing and is not counted.
- STOP is absorbing; only `rst_i` leaves it. In STOP all `wb_valid_i` inputs are ignored.
- `stat_i` values outside 1..4 with `wb_valid_i` are treated as INS (latch 4).
- Reads are combinational. ID RNONE (or any ID >= `NREGS`) returns 64'h0.
- `instret_o` wraps from 2^64-1 to 0 with no flag.

## Timing
- Reset values: all registers 0, `stat_o`=AOK (3'd1), `halted_o`=0, `instret_o`=0, state RUN.
- `rst_i` takes priority over any simultaneous commit. A write in the reset cycle is discarded.
- Write latency: the value is visible on the read ports in the cycle after the commit edge (unless bypass is enabled).
- `halted_o` rises in the cycle after the status-latching edge.
- A read and a write to the same register in the same cycle follow the bypass rules in Configuration.
- There is no backpressure; the block accepts one retiring instruction per cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through bypass on both read ports.
  - If the current cycle is a commit and `srcX_i` matches a non-RNONE destination, `valX_o` returns that incoming value.
  - `valM_i` takes priority over `valE_i`, matching the write rule.
  - Reads see the result with zero cycles of latency.
- Undefined: read ports show only registered contents. Same-cycle reads return the old value.

## Test plan
- Reset, then read every ID 0..15 -> all 0; `stat_o`=1; `instret_o`=0.
- Commit with `dstE`=0, `valE`=64'h1234 and `dstM`=3, `valM`=64'hDEAD; next cycle `srcA`=0, `srcB`=3 -> `valA_o`=64'h1234, `valB_o`=64'hDEAD; `instret_o`=1.
- Commit with `dstE`=`dstM`=5, `valE`=7, `valM`=9 -> register 5 reads 9.
- Same-cycle read of register 2 while committing `valE`=64'hAA to it:
  - With the macro: reads 64'hAA in the commit cycle.
  - Without the macro: reads the old value, then 64'hAA next cycle.
- Retire with `stat_i`=2 and `dstE`=1, `valE`=5:
  - Register 1 is unchanged and `stat_o`=2; `halted_o`=1 next cycle.
  - Later AOK commits neither write nor count.
  - A subsequent `stat_i`=3 leaves `stat_o`=2.
- While in STOP with written registers, assert `rst_i` together with a commit -> all registers 0, `stat_o`=1, `instret_o`=0, and the commit is discarded.
